// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes,
// and default frame/oversampling sizes used by RX, TX and baud gen.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEF_NUM_TICKS = 16;
  localparam int DEF_NBIT_DATA = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// 2-FF synchroniser and 3-sample majority voter for the RX line.
// Voter is combinational on registered samples so it lands on the M+1 tick.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int NUM_TICKS     = DEF_NUM_TICKS,
  parameter int LEN_NUM_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_bit,
  input  logic                     tick,
  input  logic [LEN_NUM_TICKS-1:0] cnt,
  output logic                     rx_s,
  output logic                     vote
);

  localparam int M = NUM_TICKS / 2;
  localparam logic [LEN_NUM_TICKS-1:0] C_A =
    LEN_NUM_TICKS'(M - 1);
  localparam logic [LEN_NUM_TICKS-1:0] C_B =
    LEN_NUM_TICKS'(M);

  logic meta;
  logic s0;
  logic s1;

  // bring the asynchronous line into the clk domain, idle high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx_bit;
      rx_s <= meta;
    end
  end

  // capture the first two of the three mid-bit samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (tick) begin
      if (cnt == C_A) s0 <= rx_s;
      if (cnt == C_B) s1 <= rx_s;
    end
  end

  // third sample is the live rx_s at cnt = M+1
  always_comb begin
    vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: FSM, shift register, error flags
// and a sticky valid/ack handshake toward the consumer.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int NBIT_DATA     = DEF_NBIT_DATA,
  parameter int PARITY        = PARITY_NONE,
  parameter int STOP_BITS     = 1,
  parameter int NUM_TICKS     = DEF_NUM_TICKS,
  parameter int LEN_NUM_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic                 tick,
  input  logic                 rx_ack,
  output logic                 rx_done_tick,
  output logic [NBIT_DATA-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam int IW = $clog2(NBIT_DATA + 1);
  localparam int M  = NUM_TICKS / 2;
  localparam logic [LEN_NUM_TICKS-1:0] C_DEC =
    LEN_NUM_TICKS'(M + 1);
  localparam logic [LEN_NUM_TICKS-1:0] C_END =
    LEN_NUM_TICKS'(NUM_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBIT_DATA - 1);
  localparam logic SIDX_LAST = (STOP_BITS == 2);

  state_t                   state, state_n;
  logic [LEN_NUM_TICKS-1:0] cnt, cnt_n;
  logic [IW-1:0]            idx, idx_n;
  logic [NBIT_DATA-1:0]     sh, sh_n;
  logic                     par, par_n;
  logic                     perr, perr_n;
  logic                     ferr, ferr_n;
  logic                     hi, hi_n;
  logic                     sidx, sidx_n;
  logic                     seen, seen_n;
  logic                     rx_s;
  logic                     vote;
  logic                     mid;
  logic                     last;
  logic                     complete;
  logic                     fin_ferr;
  logic                     fin_brk;

  uart_rx_sampler #(
    .NUM_TICKS     (NUM_TICKS),
    .LEN_NUM_TICKS (LEN_NUM_TICKS)
  ) u_sampler (
    .clk    (clk),
    .reset  (reset),
    .rx_bit (rx_bit),
    .tick   (tick),
    .cnt    (cnt),
    .rx_s   (rx_s),
    .vote   (vote)
  );

  // FSM state plus per-frame datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      hi    <= 1'b0;
      sidx  <= 1'b0;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      hi    <= hi_n;
      sidx  <= sidx_n;
      seen  <= seen_n;
    end
  end

  // next state; only tick cycles move the frame forward
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    par_n    = par;
    perr_n   = perr;
    ferr_n   = ferr;
    hi_n     = hi;
    sidx_n   = sidx;
    seen_n   = seen;
    complete = 1'b0;
    mid      = tick && (cnt == C_DEC);
    last     = tick && (cnt == C_END);
    if (tick && state != ST_IDLE)
      cnt_n = last ? '0 : cnt + 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (tick && rx_s) seen_n = 1'b1;
        if (tick && !rx_s && seen) begin
          state_n = ST_START;
          cnt_n   = '0;
          idx_n   = '0;
          par_n   = 1'b0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          hi_n    = 1'b0;
          sidx_n  = 1'b0;
        end
      end
      ST_START: begin
        if (mid && vote) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (last) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (mid) begin
          sh_n  = {vote, sh[NBIT_DATA-1:1]};
          par_n = par ^ vote;
          hi_n  = hi | vote;
        end
        if (last) begin
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (PARITY != PARITY_NONE) ?
                      ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (mid) begin
          perr_n = (PARITY == PARITY_ODD) ?
                   ~(par ^ vote) : (par ^ vote);
          hi_n   = hi | vote;
        end
        if (last) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (mid) begin
          if (sidx == SIDX_LAST) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
            cnt_n    = '0;
            if (fin_brk) seen_n = 1'b0;
          end else begin
            ferr_n = ferr | ~vote;
            hi_n   = hi | vote;
          end
        end else if (last) begin
          sidx_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // frame flags as they stand at the last stop-bit decision
  always_comb begin
    fin_ferr = ferr | ~vote;
    fin_brk  = ~(hi | vote);
  end

  // completion pulse, result latch and valid/ack handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_done_tick <= 1'b0;
      data_out     <= '0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= complete;
      if (complete) begin
        data_out    <= sh;
        parity_err  <= perr;
        frame_err   <= fin_ferr;
        break_det   <= fin_brk;
        overrun_err <= rx_valid & ~rx_ack;
        rx_valid    <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
